// File: rtl/md_pkg.sv
// Shared encodings and default latencies for the multiply/divide unit.
package md_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } mdOp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } mdState_t;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    function automatic logic isDivOp(input logic [1:0] op);
        case (mdOp_t'(op))
            MD_DIV, MD_DIVU: return 1'b1;
            default:         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational MIPS multiply/divide datapath: one place for the sign,
// overflow and divide-by-zero rules.
module md_arith
    import md_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  op,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_by_zero
);

    logic signed [63:0] sProd_s;
    logic        [63:0] uProd_s;

    // Full-width signed and unsigned products
    always_comb begin
        sProd_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        uProd_s = {32'd0, a} * {32'd0, b};
    end

    // Result selection; the only signed overflow case is pinned explicitly
    always_comb begin
        res_hi      = 32'd0;
        res_lo      = 32'd0;
        div_by_zero = 1'b0;
        case (mdOp_t'(op))
            MD_MULT: begin
                res_hi = sProd_s[63:32];
                res_lo = sProd_s[31:0];
            end
            MD_MULTU: begin
                res_hi = uProd_s[63:32];
                res_lo = uProd_s[31:0];
            end
            MD_DIV: begin
                if (b == 32'd0) begin
                    div_by_zero = 1'b1;
                end else if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
                    res_lo = 32'h8000_0000;
                    res_hi = 32'd0;
                end else begin
                    res_lo = $unsigned($signed(a) / $signed(b));
                    res_hi = $unsigned($signed(a) % $signed(b));
                end
            end
            MD_DIVU: begin
                if (b == 32'd0) begin
                    div_by_zero = 1'b1;
                end else begin
                    res_lo = a / b;
                    res_hi = a % b;
                end
            end
            default: div_by_zero = 1'b0;
        endcase
    end

endmodule

// File: rtl/md_checker.sv
// Simulation-only protocol checker: the stall unit must never issue into a busy unit.
module md_checker (
    input logic clk,
    input logic reset,
    input logic busy,
    input logic start,
    input logic mt_we
);

    // Flag start or MT writes presented while an operation is counting
    a_noIssueWhileBusy: assert property (@(posedge clk) disable iff (!reset)
        !(busy && (start || mt_we)))
        else $warning("md_checker: start/mt_we while busy is ignored");

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage multi-cycle multiply/divide controller owning the architectural HI/LO.
module muldiv_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mt_we,
    input  logic        mt_sel,
    input  logic [31:0] mt_data,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        md_hazard,
    output logic        done
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdState_t           state_r, nextState_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [31:0]        pendHi_r, pendLo_r, hi_r, lo_r;
    logic               pendDbz_r, busy_r, done_r;
    logic               issue_s, commit_s, mtWrite_s;
    logic [31:0]        resHi_s, resLo_s;
    logic               divByZero_s;

    md_arith uArith (
        .a           (a),
        .b           (b),
        .op          (op),
        .res_hi      (resHi_s),
        .res_lo      (resLo_s),
        .div_by_zero (divByZero_s)
    );

    md_checker uChk (
        .clk   (clk),
        .reset (reset),
        .busy  (busy_r),
        .start (start),
        .mt_we (mt_we)
    );

    // Next-state and per-cycle action decode
    always_comb begin
        nextState_s = state_r;
        issue_s     = 1'b0;
        commit_s    = 1'b0;
        mtWrite_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    issue_s     = 1'b1;
                    nextState_s = isDivOp(op) ? DIV : MUL;
                end else begin
                    mtWrite_s   = mt_we;
                end
            end
            MUL, DIV: begin
                if (cnt_r == CNT_W'(1)) begin
                    commit_s    = 1'b1;
                    nextState_s = IDLE;
                end else begin
                    nextState_s = state_r;
                end
            end
            default: nextState_s = IDLE;
        endcase
    end

    // State, counter, pending result and HI/LO registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            pendHi_r  <= 32'd0;
            pendLo_r  <= 32'd0;
            pendDbz_r <= 1'b0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r <= nextState_s;
            busy_r  <= (nextState_s != IDLE);
            done_r  <= commit_s;
            if (issue_s) begin
                cnt_r     <= isDivOp(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                pendHi_r  <= resHi_s;
                pendLo_r  <= resLo_s;
                pendDbz_r <= divByZero_s;
            end else if (state_r != IDLE) begin
                cnt_r <= cnt_r - CNT_W'(1);
            end
            // A divide by zero still runs its full latency but leaves HI/LO alone
            if (commit_s && !pendDbz_r) begin
                hi_r <= pendHi_r;
                lo_r <= pendLo_r;
            end else if (mtWrite_s) begin
                if (mt_sel) begin
                    hi_r <= mt_data;
                end else begin
                    lo_r <= mt_data;
                end
            end
        end
    end

    assign hi        = hi_r;
    assign lo        = lo_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign md_hazard = start | busy_r;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: timeline-based reference model plus
// directed vectors with hand-computed results.
module tb_muldiv_ctrl;

    localparam int NM = 5;
    localparam int ND = 10;

    logic        clk = 1'b0;
    logic        reset, start, mt_we, mt_sel;
    logic [1:0]  op;
    logic [31:0] a, b, mt_data;
    logic [31:0] hi, lo;
    logic        busy, md_hazard, done;

    int checks = 0;
    int errors = 0;
    logic chkOn = 1'b0;

    muldiv_ctrl #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .mt_we(mt_we), .mt_sel(mt_sel), .mt_data(mt_data),
        .hi(hi), .lo(lo), .busy(busy), .md_hazard(md_hazard), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference result from plain 64-bit arithmetic: {div_by_zero, hi, lo}
    function automatic logic [64:0] refOp(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint          sp, q, r;
        longint unsigned up;
        case (o)
            2'd0: begin
                sp = longint'($signed(x)) * longint'($signed(y));
                return {1'b0, sp[63:0]};
            end
            2'd1: begin
                up = {32'd0, x} * {32'd0, y};
                return {1'b0, up[63:0]};
            end
            2'd2: begin
                if (y == 32'd0) return {1'b1, 64'd0};
                q = longint'($signed(x)) / longint'($signed(y));
                r = longint'($signed(x)) % longint'($signed(y));
                return {1'b0, r[31:0], q[31:0]};
            end
            default: begin
                if (y == 32'd0) return {1'b1, 64'd0};
                return {1'b0, x % y, x / y};
            end
        endcase
    endfunction

    // Model: an accepted issue at cycle T is busy for T+1..T+N and commits at the end of T+N
    int          mCyc = 0, mIssue = 0, mLen = 0;
    logic        mActive = 1'b0, mDone = 1'b0;
    logic [31:0] mHi = 32'd0, mLo = 32'd0;
    logic [64:0] mPend = 65'd0;

    always @(posedge clk) begin
        mDone <= 1'b0;
        if (!reset) begin
            mActive <= 1'b0;
            mHi     <= 32'd0;
            mLo     <= 32'd0;
        end else if (mActive) begin
            if (mCyc == mIssue + mLen) begin
                mActive <= 1'b0;
                mDone   <= 1'b1;
                if (!mPend[64]) begin
                    mHi <= mPend[63:32];
                    mLo <= mPend[31:0];
                end
            end
        end else if (start) begin
            mActive <= 1'b1;
            mIssue  <= mCyc;
            mLen    <= op[1] ? ND : NM;
            mPend   <= refOp(op, a, b);
        end else if (mt_we) begin
            if (mt_sel) mHi <= mt_data;
            else        mLo <= mt_data;
        end
        mCyc <= mCyc + 1;
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chkOn) begin
            chk("hi", hi, mHi);
            chk("lo", lo, mLo);
            chk("busy", {31'd0, busy}, {31'd0, mActive});
            chk("done", {31'd0, done}, {31'd0, mDone});
            chk("md_hazard", {31'd0, md_hazard}, {31'd0, start | mActive});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, count busy/done through the latency window, then pin literal results
    task automatic runOp(input string nm, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input int n, input logic [31:0] eHi, input logic [31:0] eLo);
        int bc, dc;
        op = o; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
        bc = 0; dc = 0;
        for (int i = 0; i < n; i++) begin
            if (busy) bc++;
            if (done) dc++;
            tick();
        end
        chk({nm, " busy cycles"}, bc, n);
        chk({nm, " early done"}, dc, 0);
        chk({nm, " done"}, {31'd0, done}, 32'd1);
        chk({nm, " busy after"}, {31'd0, busy}, 32'd0);
        chk({nm, " hi"}, hi, eHi);
        chk({nm, " lo"}, lo, eLo);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        reset = 1'b0; start = 1'b0; mt_we = 1'b0; mt_sel = 1'b0;
        op = 2'd0; a = 32'd0; b = 32'd0; mt_data = 32'd0;
        tick();
        chkOn = 1'b1;
        tick();
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        reset = 1'b1;
        tick();

        runOp("MULT", 2'd0, 32'hFFFF_FFFE, 32'd3, NM, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        // back-to-back: issued in the same cycle done is high
        runOp("MULTU", 2'd1, 32'hFFFF_FFFF, 32'd2, NM, 32'h0000_0001, 32'hFFFF_FFFE);
        runOp("DIV", 2'd2, 32'hFFFF_FFF9, 32'd2, ND, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        runOp("DIV ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, ND, 32'h0000_0000, 32'h8000_0000);

        mt_we = 1'b1; mt_sel = 1'b1; mt_data = 32'h1234_5678;
        tick();
        mt_we = 1'b0;
        chk("MTHI hi", hi, 32'h1234_5678);
        chk("MTHI lo", lo, 32'h8000_0000);
        chk("MTHI busy", {31'd0, busy}, 32'd0);

        runOp("DIVU by zero", 2'd3, 32'd5, 32'd0, ND, 32'h1234_5678, 32'h8000_0000);
        tick();

        // reset during busy cycle 4 discards the op
        op = 2'd2; a = 32'd100; b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk("pre-reset busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("mid reset busy", {31'd0, busy}, 32'd0);
        chk("mid reset hi", hi, 32'd0);
        chk("mid reset lo", lo, 32'd0);
        dc = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) dc++;
            tick();
        end
        chk("no done after reset", dc, 0);
        runOp("MULT 6x7", 2'd0, 32'd6, 32'd7, NM, 32'd0, 32'd42);
        tick();

        // start and mt_we together: start wins; later requests during busy are dropped
        op = 2'd1; a = 32'd3; b = 32'd4; start = 1'b1;
        mt_we = 1'b1; mt_sel = 1'b0; mt_data = 32'hDEAD_BEEF;
        tick();
        start = 1'b0; mt_we = 1'b0;
        tick();
        op = 2'd3; a = 32'd9; b = 32'd3; start = 1'b1;
        mt_we = 1'b1; mt_sel = 1'b1; mt_data = 32'hCAFE_F00D;
        tick();
        start = 1'b0; mt_we = 1'b0;
        tick(); tick(); tick();
        chk("collide done", {31'd0, done}, 32'd1);
        chk("collide hi", hi, 32'd0);
        chk("collide lo", lo, 32'd12);
        dc = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done || busy) dc++;
        end
        chk("no second op", dc, 0);
        chk("final hi", hi, 32'd0);
        chk("final lo", lo, 32'd12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
